// File: rtl/hash_out_serializer.sv
// Captures a finished BLAKE2 digest in one cycle and streams its first nn bytes
// out least-significant byte first over an 8-bit valid/ready port.
module hash_out_serializer #(
  parameter int NN_MAX = 64,
  parameter int CNT_W  = 7
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  res_v_i,
  input  logic [8*NN_MAX-1:0]   res_i,
  input  logic [7:0]            nn_i,
  input  logic                  abort_i,
  input  logic                  ready_i,
  output logic                  hash_v_o,
  output logic [7:0]            hash_o,
  output logic                  hash_last_o,
  output logic                  busy_o,
  output logic                  overrun_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [8*NN_MAX-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic                overrun_q, overrun_d;

  logic                nn_in_range;
  logic [CNT_W-1:0]    nn_eff;
  logic                accept;
  logic                last_byte;

  // Out-of-range lengths (0 or larger than the digest bus) mean "whole digest".
  assign nn_in_range = (nn_i != 8'd0) && (int'(nn_i) <= NN_MAX);
  assign nn_eff      = nn_in_range ? CNT_W'(nn_i) : CNT_W'(NN_MAX);

  // Handshake: a byte transfers on every cycle where hash_v_o & ready_i; while
  // ready_i is low the byte, valid and last flags hold; ready_i is ignored when
  // hash_v_o is low.
  assign accept    = (state_q == ST_SEND) && ready_i;
  assign last_byte = (rem_q == CNT_W'(1));

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    rem_d     = rem_q;
    overrun_d = 1'b0;
    if (abort_i) begin
      state_d = ST_IDLE;
      shreg_d = '0;
      rem_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (res_v_i) begin
            state_d = ST_SEND;
            shreg_d = res_i;
            rem_d   = nn_eff;
          end
        end
        ST_SEND: begin
          overrun_d = res_v_i;
          if (accept) begin
            if (last_byte) begin
              // Clear so bytes beyond nn_eff can never surface on hash_o.
              state_d = ST_IDLE;
              shreg_d = '0;
              rem_d   = '0;
            end else begin
              shreg_d = {8'h00, shreg_q[8*NN_MAX-1:8]};
              rem_d   = rem_q - CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          shreg_d = '0;
          rem_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      rem_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      rem_q     <= rem_d;
      overrun_q <= overrun_d;
    end
  end

  assign hash_v_o    = (state_q == ST_SEND);
  assign busy_o      = (state_q == ST_SEND);
  assign hash_o      = shreg_q[7:0];
  assign hash_last_o = hash_v_o & last_byte;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_hash_out_serializer.sv
// Directed bench for hash_out_serializer: inputs change on the falling edge,
// outputs are checked on the falling edge before the next rising edge.
module tb_hash_out_serializer;

  localparam int NN_MAX = 64;
  localparam int CNT_W  = 7;

  logic                clk;
  logic                nreset;
  logic                res_v_i;
  logic [8*NN_MAX-1:0] res_i;
  logic [7:0]          nn_i;
  logic                abort_i;
  logic                ready_i;
  logic                hash_v_o;
  logic [7:0]          hash_o;
  logic                hash_last_o;
  logic                busy_o;
  logic                overrun_o;

  int total;
  int bad;

  logic [8*NN_MAX-1:0] pat;
  logic [8*NN_MAX-1:0] alt;

  hash_out_serializer #(.NN_MAX(NN_MAX), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .nreset      (nreset),
    .res_v_i     (res_v_i),
    .res_i       (res_i),
    .nn_i        (nn_i),
    .abort_i     (abort_i),
    .ready_i     (ready_i),
    .hash_v_o    (hash_v_o),
    .hash_o      (hash_o),
    .hash_last_o (hash_last_o),
    .busy_o      (busy_o),
    .overrun_o   (overrun_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver: one-cycle res_v_i pulse; returns on the falling edge where byte 0 shows.
  task automatic pulse_res(input logic [7:0] nn, input logic [8*NN_MAX-1:0] data);
    @(negedge clk);
    res_v_i = 1'b1;
    nn_i    = nn;
    res_i   = data;
    @(negedge clk);
    res_v_i = 1'b0;
  endtask

  task automatic test_reset();
    nreset  = 1'b0;
    res_v_i = 1'b0;
    abort_i = 1'b0;
    ready_i = 1'b0;
    nn_i    = 8'd0;
    res_i   = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({hash_v_o, hash_o, hash_last_o, busy_o, overrun_o} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b o=%h last=%b busy=%b ovr=%b want all 0",
               hash_v_o, hash_o, hash_last_o, busy_o, overrun_o);
    end
    nreset = 1'b1;
    @(negedge clk);
    total++;
    if ({hash_v_o, busy_o} !== 2'b00) begin
      bad++;
      $display("FAIL reset_release_idle: got v=%b busy=%b want 0 0", hash_v_o, busy_o);
    end
  endtask

  task automatic test_stream32();
    ready_i = 1'b1;
    pulse_res(8'd32, pat);
    for (int i = 0; i < 32; i++) begin
      total++;
      if ({hash_v_o, hash_o, hash_last_o, busy_o} !== {1'b1, 8'(i + 1), (i == 31), 1'b1}) begin
        bad++;
        $display("FAIL stream32_byte%0d: got v=%b o=%h last=%b busy=%b want 1 %h %b 1",
                 i, hash_v_o, hash_o, hash_last_o, busy_o, 8'(i + 1), (i == 31));
      end
      @(negedge clk);
    end
    total++;
    if ({hash_v_o, hash_o, hash_last_o, busy_o} !== 11'h000) begin
      bad++;
      $display("FAIL stream32_end: got v=%b o=%h last=%b busy=%b want all 0",
               hash_v_o, hash_o, hash_last_o, busy_o);
    end
  endtask

  task automatic test_stall();
    logic [6:0] rdy_pat;
    int idx;
    rdy_pat = 7'b1011001; // applied LSB first: 1,0,0,1,1,0,1
    idx = 0;
    ready_i = 1'b0;
    pulse_res(8'd4, pat);
    for (int c = 0; c < 7; c++) begin
      total++;
      if ({hash_v_o, hash_o, hash_last_o} !== {1'b1, 8'(idx + 1), (idx == 3)}) begin
        bad++;
        $display("FAIL stall_cycle%0d: got v=%b o=%h last=%b want 1 %h %b",
                 c, hash_v_o, hash_o, hash_last_o, 8'(idx + 1), (idx == 3));
      end
      ready_i = rdy_pat[c];
      @(negedge clk);
      if (rdy_pat[c]) idx++;
    end
    total++;
    if ({hash_v_o, hash_o, busy_o} !== 10'h000) begin
      bad++;
      $display("FAIL stall_end: got v=%b o=%h busy=%b want 0 00 0", hash_v_o, hash_o, busy_o);
    end
  endtask

  task automatic test_length(input logic [7:0] nn);
    int errs;
    errs = 0;
    ready_i = 1'b1;
    @(negedge clk);
    pulse_res(nn, pat);
    for (int i = 0; i < NN_MAX; i++) begin
      total++;
      if ({hash_v_o, hash_o, hash_last_o} !== {1'b1, 8'(i + 1), (i == NN_MAX - 1)}) begin
        bad++;
        $display("FAIL len%0d_byte%0d: got v=%b o=%h last=%b want 1 %h %b",
                 nn, i, hash_v_o, hash_o, hash_last_o, 8'(i + 1), (i == NN_MAX - 1));
      end
      @(negedge clk);
    end
    total++;
    if ({hash_v_o, busy_o} !== 2'b00) begin
      bad++;
      $display("FAIL len%0d_end: got v=%b busy=%b want 0 0", nn, hash_v_o, busy_o);
    end
  endtask

  task automatic test_overrun();
    ready_i = 1'b1;
    @(negedge clk);
    pulse_res(8'd8, pat);
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({hash_v_o, hash_o, hash_last_o, overrun_o} !== {1'b1, 8'(i + 1), (i == 7), (i == 3)}) begin
        bad++;
        $display("FAIL overrun_byte%0d: got v=%b o=%h last=%b ovr=%b want 1 %h %b %b",
                 i, hash_v_o, hash_o, hash_last_o, overrun_o, 8'(i + 1), (i == 7), (i == 3));
      end
      res_v_i = (i == 2) || (i == 7);
      nn_i    = 8'd3;
      res_i   = alt;
      @(negedge clk);
    end
    res_v_i = 1'b0;
    total++;
    if ({overrun_o, hash_v_o, busy_o} !== 3'b100) begin
      bad++;
      $display("FAIL overrun_last_accept: got ovr=%b v=%b busy=%b want 1 0 0",
               overrun_o, hash_v_o, busy_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({overrun_o, hash_v_o, hash_o} !== 10'h000) begin
        bad++;
        $display("FAIL overrun_no_second%0d: got ovr=%b v=%b o=%h want 0 0 00",
                 i, overrun_o, hash_v_o, hash_o);
      end
    end
  endtask

  task automatic test_abort();
    ready_i = 1'b1;
    @(negedge clk);
    pulse_res(8'd64, pat);
    for (int i = 0; i < 6; i++) begin
      total++;
      if ({hash_v_o, hash_o} !== {1'b1, 8'(i + 1)}) begin
        bad++;
        $display("FAIL abort_pre%0d: got v=%b o=%h want 1 %h", i, hash_v_o, hash_o, 8'(i + 1));
      end
      if (i == 5) begin
        abort_i = 1'b1;
        res_v_i = 1'b1;
        nn_i    = 8'd2;
        res_i   = alt;
      end
      @(negedge clk);
    end
    abort_i = 1'b0;
    res_v_i = 1'b0;
    total++;
    if ({hash_v_o, busy_o, overrun_o, hash_o} !== 11'h000) begin
      bad++;
      $display("FAIL abort_drop: got v=%b busy=%b ovr=%b o=%h want 0 0 0 00",
               hash_v_o, busy_o, overrun_o, hash_o);
    end
    @(negedge clk);
    total++;
    if ({hash_v_o, overrun_o} !== 2'b00) begin
      bad++;
      $display("FAIL abort_stays_idle: got v=%b ovr=%b want 0 0", hash_v_o, overrun_o);
    end
    pulse_res(8'd4, pat);
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({hash_v_o, hash_o, hash_last_o} !== {1'b1, 8'(i + 1), (i == 3)}) begin
        bad++;
        $display("FAIL abort_restart%0d: got v=%b o=%h last=%b want 1 %h %b",
                 i, hash_v_o, hash_o, hash_last_o, 8'(i + 1), (i == 3));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    ready_i = 1'b1;
    @(negedge clk);
    pulse_res(8'd16, pat);
    repeat (3) @(negedge clk);
    total++;
    if ({hash_v_o, hash_o} !== {1'b1, 8'h04}) begin
      bad++;
      $display("FAIL areset_pre: got v=%b o=%h want 1 04", hash_v_o, hash_o);
    end
    #2 nreset = 1'b0;
    #1;
    total++;
    if ({hash_v_o, hash_o, hash_last_o, busy_o, overrun_o} !== 12'h000) begin
      bad++;
      $display("FAIL areset_immediate: got v=%b o=%h last=%b busy=%b ovr=%b want all 0",
               hash_v_o, hash_o, hash_last_o, busy_o, overrun_o);
    end
    @(negedge clk);
    nreset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if ({hash_v_o, busy_o, hash_o} !== 10'h000) begin
        bad++;
        $display("FAIL areset_idle%0d: got v=%b busy=%b o=%h want 0 0 00", i, hash_v_o, busy_o, hash_o);
      end
    end
    pulse_res(8'd2, pat);
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({hash_v_o, hash_o, hash_last_o} !== {1'b1, 8'(i + 1), (i == 1)}) begin
        bad++;
        $display("FAIL areset_restart%0d: got v=%b o=%h last=%b want 1 %h %b",
                 i, hash_v_o, hash_o, hash_last_o, 8'(i + 1), (i == 1));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int k = 0; k < NN_MAX; k++) begin
      pat[8*k +: 8] = 8'(k + 1);
      alt[8*k +: 8] = 8'hAA;
    end
    test_reset();
    test_stream32();
    test_stall();
    test_length(8'd0);
    test_length(8'd200);
    test_overrun();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
